histogram_esitleme_p: RTL and testbench
=======================================

// Module: histogram_esitleme_p
// PURPOSE
// Parametrised successor of the fixed 8-bit histogram equaliser. Accumulates one frame of
// PIKSEL_SAYISI pixels into an internal histogram, builds the cumulative sum, then streams a
// 2^PIXEL_BIT-entry equalisation LUT (bin address + mapped value) over a valid/ready handshake.
// It sits behind the camera pixel stream. The LUT feeds the pixel remapper.
// PARAMETERS
// PIXEL_BIT    8      pixel width; histogram has L = 2^PIXEL_BIT bins
// PIKSEL_SAYISI 76800 pixels per frame (320x240); frame ends after this many accepted pixels
// SAYAC_BIT    17     bin/CDF counter width; must satisfy 2^SAYAC_BIT > PIKSEL_SAYISI
// KIRPMA_ESIK  1024   per-bin clip limit (used only with HISTOGRAM_KIRPMA_EN)
// PORTS
// clk_i            in   1          clock, all logic on rising edge
// rst_i            in   1          asynchronous, active-high reset
// etkin_i          in   1          pixel valid
// pixel_i          in   PIXEL_BIT  pixel value
// hazir_o          out  1          block accepts pixels (high only in TOPLA)
// sonuc_gecerli_o  out  1          LUT entry valid
// sonuc_hazir_i    in   1          downstream ready
// sonuc_adres_o    out  PIXEL_BIT  LUT bin index, 0..L-1 ascending
// sonuc_o          out  PIXEL_BIT  equalised value for that bin
// bitti_o          out  1          1-cycle pulse after last LUT entry and histogram clear finish
// BEHAVIOUR
// - Reset: state=TEMIZLE, all outputs 0, pixel counter 0; any partial frame is discarded.
// - FSM: TEMIZLE -> TOPLA -> BOSALT -> KUMULATIF -> BOL -> CIKIS -> (BOL | TEMIZLE).
// - TEMIZLE: writes 0 to bins 0..L-1, one per cycle (L cycles); then TOPLA. bitti_o pulses on
//   the TEMIZLE->TOPLA edge except on the first clear after reset.
// - TOPLA: hazir_o=1; pixel accepted when etkin_i&&hazir_o. 2-stage read-modify-write
//   (read, then write +1). Back-to-back equal pixels use a forwarding path: no lost increments,
//   no stall. The accepted count reaching PIKSEL_SAYISI drops hazir_o in the next cycle.
//   etkin_i while hazir_o=0 is ignored and not counted.
// - BOSALT: 2 cycles draining the RMW pipe.
// - KUMULATIF: one bin per cycle, cdf[k]=cdf[k-1]+h[k], written back in place. Toplam=cdf[L-1].
// - BOL: per bin, num = cdf[k]*(L-1) (SAYAC_BIT+PIXEL_BIT wide). Sequential restoring divider
//   num/Toplam, floor, SAYAC_BIT+PIXEL_BIT cycles; quotient saturated to L-1.
// - CIKIS: sonuc_gecerli_o=1 with adres/sonuc stable until sonuc_hazir_i=1 (AXI-style; the value
//   must not change while valid&&!ready). The handshake advances to the next bin. After bin L-1
//   -> TEMIZLE.
// - Max pixel value (L-1) and bin L-1 wrap: bin counters never overflow given the parameter rule.
// - Reset asserted in any state aborts immediately; outputs 0 while rst_i is high.
// CONFIGURATION
// - HISTOGRAM_KIRPMA_EN defined: in TOPLA a bin at KIRPMA_ESIK is not incremented (saturates).
//   Toplam is then the clipped sum, and the LUT uses the clipped histogram.
// - Not defined: bins count freely; KIRPMA_ESIK is unused; Toplam == PIKSEL_SAYISI.
// TESTING
// 1 Constant image, all 0x80 -> LUT[k]=0 for k<128, LUT[k]=255 for k>=128; bitti_o pulses once.
// 2 Ramp, each value 0..255 exactly 300 times -> LUT[k]=k for all k (identity).
// 3 Repeat pattern 5,5,5,7,5 continuously -> hist[5]=N*4/5, hist[7]=N/5 exactly (forwarding).
// 4 sonuc_hazir_i low 10 cycles at bin 40 -> adres=40, sonuc held stable; no bin skipped or duplicated.
// 5 rst_i pulse at pixel 1000, then a full constant-0x10 frame -> only the new frame counted.
//   Result: LUT[k]=0 for k<16, 255 for k>=16.
// 6 HISTOGRAM_KIRPMA_EN, KIRPMA_ESIK=1000: half 0x00/half 0xFF -> Toplam=2000,
//   LUT[0..254]=127, LUT[255]=255.

Source files
------------

// File: rtl/histogram_esitleme_p.sv
// histogram_esitleme_p: accumulates one frame into a histogram, builds the CDF in place, streams an equalisation LUT.
// Latency: L clear + PIKSEL_SAYISI accepted pixels + 2 drain + L cumulative + L*(SAYAC_BIT+PIXEL_BIT) divide cycles plus one output cycle per bin.
// Backpressure: hazir_o high only while collecting; each LUT entry is held on sonuc_* while sonuc_gecerli_o && !sonuc_hazir_i.
// Option macro HISTOGRAM_KIRPMA_EN: saturates every bin at KIRPMA_ESIK while collecting.
module histogram_esitleme_p #(
  parameter int PIXEL_BIT     = 8,
  parameter int PIKSEL_SAYISI = 76800,
  parameter int SAYAC_BIT     = 17,
  parameter int KIRPMA_ESIK   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 etkin_i,
  input  logic [PIXEL_BIT-1:0] pixel_i,
  output logic                 hazir_o,
  output logic                 sonuc_gecerli_o,
  input  logic                 sonuc_hazir_i,
  output logic [PIXEL_BIT-1:0] sonuc_adres_o,
  output logic [PIXEL_BIT-1:0] sonuc_o,
  output logic                 bitti_o
);

  localparam int L  = 1 << PIXEL_BIT;
  localparam int NW = SAYAC_BIT + PIXEL_BIT;
  localparam int CW = $clog2(NW + 1);

`ifdef HISTOGRAM_KIRPMA_EN
  localparam bit KIRPMA_ACIK = 1'b1;
`else
  localparam bit KIRPMA_ACIK = 1'b0;
`endif

  typedef enum logic [2:0] {TEMIZLE, TOPLA, BOSALT, KUMULATIF, BOL, CIKIS} durum_t;

  durum_t                 durum_q, durum_d;
  logic [PIXEL_BIT-1:0]   idx_q, idx_d;
  logic [SAYAC_BIT-1:0]   pix_cnt_q, pix_cnt_d;
  logic                   ilk_q, ilk_d;
  logic                   bitti_q, bitti_d;
  logic                   s1_vld_q, s1_vld_d;
  logic [PIXEL_BIT-1:0]   s1_adr_q, s1_adr_d;
  logic                   s2_vld_q, s2_vld_d;
  logic [PIXEL_BIT-1:0]   s2_adr_q, s2_adr_d;
  logic [SAYAC_BIT-1:0]   s2_val_q, s2_val_d;
  logic [SAYAC_BIT-1:0]   acc_q, acc_d;
  logic [SAYAC_BIT-1:0]   toplam_q, toplam_d;
  logic [SAYAC_BIT-1:0]   rem_q, rem_d;
  logic [NW-1:0]          num_q, num_d;
  logic [CW-1:0]          div_cnt_q, div_cnt_d;
  logic [PIXEL_BIT-1:0]   sonuc_q, sonuc_d;

  logic [SAYAC_BIT-1:0]   hist_mem [L];
  logic                   mem_we;
  logic [PIXEL_BIT-1:0]   mem_wa;
  logic [SAYAC_BIT-1:0]   mem_wd;

  logic                   kabul, son_piksel, son_bin;
  logic [PIXEL_BIT-1:0]   sonraki_idx;
  logic [SAYAC_BIT-1:0]   taban, kum;
  logic                   artir, buyuk;
  logic [SAYAC_BIT:0]     rem_kay;
  logic [SAYAC_BIT-1:0]   fark;

  // cdf*(L-1) computed as (cdf << PIXEL_BIT) - cdf
  function automatic logic [NW-1:0] carp(input logic [SAYAC_BIT-1:0] c);
    return {c, {PIXEL_BIT{1'b0}}} - NW'(c);
  endfunction

  assign kabul       = etkin_i && (durum_q == TOPLA);
  assign son_piksel  = (pix_cnt_q == SAYAC_BIT'(PIKSEL_SAYISI - 1));
  assign son_bin     = &idx_q;
  assign sonraki_idx = idx_q + 1'b1;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) durum_q <= TEMIZLE;
    else       durum_q <= durum_d;
  end

  // Next-state logic
  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      TEMIZLE:   if (son_bin) durum_d = TOPLA;
      TOPLA:     if (kabul && son_piksel) durum_d = BOSALT;
      BOSALT:    if (idx_q == PIXEL_BIT'(1)) durum_d = KUMULATIF;
      KUMULATIF: if (son_bin) durum_d = BOL;
      BOL:       if (div_cnt_q == CW'(NW - 1)) durum_d = CIKIS;
      CIKIS:     if (sonuc_hazir_i) durum_d = son_bin ? TEMIZLE : BOL;
      default:   durum_d = TEMIZLE;
    endcase
  end

  // Datapath: RMW increment pipe with forwarding, CDF pass, restoring divider
  always_comb begin
    idx_d     = idx_q;
    pix_cnt_d = pix_cnt_q;
    ilk_d     = ilk_q;
    bitti_d   = 1'b0;
    acc_d     = acc_q;
    toplam_d  = toplam_q;
    rem_d     = rem_q;
    num_d     = num_q;
    div_cnt_d = div_cnt_q;
    sonuc_d   = sonuc_q;

    // A write still sitting in stage 2 is newer than the array contents
    taban    = (s2_vld_q && (s2_adr_q == s1_adr_q)) ? s2_val_q : hist_mem[s1_adr_q];
    artir    = !KIRPMA_ACIK || (taban < SAYAC_BIT'(KIRPMA_ESIK));
    s1_vld_d = kabul;
    s1_adr_d = pixel_i;
    s2_vld_d = s1_vld_q;
    s2_adr_d = s1_adr_q;
    s2_val_d = taban + {{(SAYAC_BIT-1){1'b0}}, artir};

    mem_we = s2_vld_q;
    mem_wa = s2_adr_q;
    mem_wd = s2_val_q;

    kum     = acc_q + hist_mem[idx_q];
    rem_kay = {rem_q, num_q[NW-1]};
    buyuk   = (rem_kay >= {1'b0, toplam_q});
    fark    = rem_kay[SAYAC_BIT-1:0] - toplam_q;

    case (durum_q)
      TEMIZLE: begin
        mem_we    = 1'b1;
        mem_wa    = idx_q;
        mem_wd    = '0;
        idx_d     = sonraki_idx;
        pix_cnt_d = '0;
        if (son_bin) begin
          bitti_d = !ilk_q;
          ilk_d   = 1'b0;
        end
      end
      TOPLA: begin
        if (kabul) pix_cnt_d = pix_cnt_q + 1'b1;
      end
      BOSALT: begin
        idx_d = (idx_q == PIXEL_BIT'(1)) ? '0 : sonraki_idx;
        acc_d = '0;
      end
      KUMULATIF: begin
        mem_we = 1'b1;
        mem_wa = idx_q;
        mem_wd = kum;
        acc_d  = kum;
        idx_d  = sonraki_idx;
        if (son_bin) begin
          toplam_d  = kum;
          num_d     = carp(hist_mem[sonraki_idx]);
          rem_d     = '0;
          div_cnt_d = '0;
        end
      end
      BOL: begin
        rem_d     = buyuk ? fark : rem_kay[SAYAC_BIT-1:0];
        num_d     = {num_q[NW-2:0], buyuk};
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == CW'(NW - 1))
          sonuc_d = (num_d > NW'(L - 1)) ? '1 : num_d[PIXEL_BIT-1:0];
      end
      CIKIS: begin
        if (sonuc_hazir_i) begin
          idx_d     = sonraki_idx;
          num_d     = carp(hist_mem[sonraki_idx]);
          rem_d     = '0;
          div_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; a reset throws away any partial frame
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      pix_cnt_q <= '0;
      ilk_q     <= 1'b1;
      bitti_q   <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_adr_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_adr_q  <= '0;
      s2_val_q  <= '0;
      acc_q     <= '0;
      toplam_q  <= '0;
      rem_q     <= '0;
      num_q     <= '0;
      div_cnt_q <= '0;
      sonuc_q   <= '0;
    end else begin
      idx_q     <= idx_d;
      pix_cnt_q <= pix_cnt_d;
      ilk_q     <= ilk_d;
      bitti_q   <= bitti_d;
      s1_vld_q  <= s1_vld_d;
      s1_adr_q  <= s1_adr_d;
      s2_vld_q  <= s2_vld_d;
      s2_adr_q  <= s2_adr_d;
      s2_val_q  <= s2_val_d;
      acc_q     <= acc_d;
      toplam_q  <= toplam_d;
      rem_q     <= rem_d;
      num_q     <= num_d;
      div_cnt_q <= div_cnt_d;
      sonuc_q   <= sonuc_d;
    end
  end

  // Histogram storage; contents are rebuilt by the clear pass so no reset is needed
  always_ff @(posedge clk_i) begin
    if (mem_we) hist_mem[mem_wa] <= mem_wd;
  end

  // Outputs decoded from state; LUT fields forced to 0 outside the output phase
  always_comb begin
    hazir_o         = (durum_q == TOPLA);
    sonuc_gecerli_o = (durum_q == CIKIS);
    sonuc_adres_o   = sonuc_gecerli_o ? idx_q : '0;
    sonuc_o         = sonuc_gecerli_o ? sonuc_q : '0;
    bitti_o         = bitti_q;
  end

endmodule

// File: tb/tb_histogram_esitleme_p.sv
// Directed bench for histogram_esitleme_p with a reduced 1280-pixel frame.
// Expected LUT values are hand-derived per frame pattern.
module tb_histogram_esitleme_p;

  localparam int N = 1280;
  localparam int L = 256;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       etkin_i;
  logic [7:0] pixel_i;
  logic       hazir_o;
  logic       sonuc_gecerli_o;
  logic       sonuc_hazir_i;
  logic [7:0] sonuc_adres_o;
  logic [7:0] sonuc_o;
  logic       bitti_o;

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;
  int bitti_sayac    = 0;
  bit iptal          = 1'b0;

  histogram_esitleme_p #(
    .PIXEL_BIT    (8),
    .PIKSEL_SAYISI(N),
    .SAYAC_BIT    (11),
`ifdef HISTOGRAM_KIRPMA_EN
    .KIRPMA_ESIK  (500)
`else
    .KIRPMA_ESIK  (1024)
`endif
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .etkin_i        (etkin_i),
    .pixel_i        (pixel_i),
    .hazir_o        (hazir_o),
    .sonuc_gecerli_o(sonuc_gecerli_o),
    .sonuc_hazir_i  (sonuc_hazir_i),
    .sonuc_adres_o  (sonuc_adres_o),
    .sonuc_o        (sonuc_o),
    .bitti_o        (bitti_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    if (bitti_o) bitti_sayac++;
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  // Pixel generators: 0 const 0x80, 1 ramp x5, 2 pattern 5,5,5,7,5, 3 const 0x10, 4 half 0x00 / half 0xFF
  function automatic logic [7:0] piksel(input int mod, input int i);
    case (mod)
      0: return 8'h80;
      1: return 8'(i / 5);
      2: return ((i % 5) == 3) ? 8'd7 : 8'd5;
      3: return 8'h10;
      default: return (i < N / 2) ? 8'h00 : 8'hFF;
    endcase
  endfunction

  // 1024*255/1280 = 204; clipped 500*255/1000 = 127
  function automatic logic [31:0] beklenen(input int mod, input int k);
    case (mod)
      0: return (k < 128) ? 0 : 255;
      1: return k;
      2: return (k < 5) ? 0 : ((k < 7) ? 204 : 255);
      3: return (k < 16) ? 0 : 255;
      default: return (k < 255) ? 127 : 255;
    endcase
  endfunction

  task automatic bekle_hazir();
    int c = 0;
    @(negedge clk_i);
    while (!hazir_o && c < 1000) begin
      @(negedge clk_i);
      c++;
    end
    if (!hazir_o) begin
      kontrol("hazir_zaman_asimi", 32'(c), 0);
      iptal = 1'b1;
    end
  endtask

  task automatic lut_oku(input int mod, input int durak);
    int c;
    for (int k = 0; k < L; k++) begin
      c = 0;
      while (!sonuc_gecerli_o && c < 400) begin
        @(negedge clk_i);
        c++;
      end
      if (!sonuc_gecerli_o) begin
        kontrol("lut_zaman_asimi", 32'(k), 32'(L));
        iptal = 1'b1;
        return;
      end
      kontrol("lut_adres", 32'(sonuc_adres_o), 32'(k));
      kontrol("lut_deger", 32'(sonuc_o), beklenen(mod, k));
      if (k == durak) begin
        sonuc_hazir_i = 1'b0;
        repeat (10) begin
          @(negedge clk_i);
          kontrol("durak_gecerli", 32'(sonuc_gecerli_o), 1);
          kontrol("durak_adres", 32'(sonuc_adres_o), 32'(k));
          kontrol("durak_deger", 32'(sonuc_o), beklenen(mod, k));
        end
        sonuc_hazir_i = 1'b1;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic cerceve(input int mod, input int durak);
    int i = 0;
    int cyc = 0;
    int b0;
    bekle_hazir();
    if (iptal) return;
    b0 = bitti_sayac;
    while (i < N) begin
      @(negedge clk_i);
      cyc++;
      if (!hazir_o) begin
        kontrol("hazir_erken", 32'(i), 32'(N));
        etkin_i = 1'b0;
        iptal   = 1'b1;
        return;
      end
      if ((cyc % 11) == 5) begin
        etkin_i = 1'b0;
      end else begin
        etkin_i = 1'b1;
        pixel_i = piksel(mod, i);
        i++;
      end
    end
    @(negedge clk_i);
    kontrol("hazir_dusus", 32'(hazir_o), 0);
    // Pixels offered while not ready must be ignored
    etkin_i = 1'b1;
    pixel_i = 8'hFF;
    repeat (20) @(negedge clk_i);
    etkin_i = 1'b0;
    lut_oku(mod, durak);
    if (iptal) return;
    bekle_hazir();
    if (iptal) return;
    @(negedge clk_i);
    kontrol("bitti_darbe", 32'(bitti_sayac - b0), 1);
  endtask

  initial begin
    int b0;
    rst_i         = 1'b1;
    etkin_i       = 1'b0;
    pixel_i       = '0;
    sonuc_hazir_i = 1'b1;
    repeat (2) @(negedge clk_i);
    kontrol("rst_hazir", 32'(hazir_o), 0);
    kontrol("rst_gecerli", 32'(sonuc_gecerli_o), 0);
    kontrol("rst_adres", 32'(sonuc_adres_o), 0);
    kontrol("rst_sonuc", 32'(sonuc_o), 0);
    kontrol("rst_bitti", 32'(bitti_o), 0);
    rst_i = 1'b0;
    bekle_hazir();
    if (!iptal) begin
      @(negedge clk_i);
      kontrol("ilk_temizle_bitti_yok", 32'(bitti_sayac), 0);
    end

`ifdef HISTOGRAM_KIRPMA_EN
    if (!iptal) cerceve(4, -1);
`else
    if (!iptal) cerceve(0, -1);
    if (!iptal) cerceve(1, 40);
    if (!iptal) cerceve(2, -1);
    if (!iptal) begin
      // Partial frame cut by reset at pixel 1000
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk_i);
        etkin_i = 1'b1;
        pixel_i = piksel(1, i);
      end
      @(negedge clk_i);
      etkin_i = 1'b0;
      rst_i   = 1'b1;
      @(negedge clk_i);
      kontrol("ara_rst_hazir", 32'(hazir_o), 0);
      kontrol("ara_rst_gecerli", 32'(sonuc_gecerli_o), 0);
      kontrol("ara_rst_bitti", 32'(bitti_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      b0 = bitti_sayac;
      bekle_hazir();
      if (!iptal) begin
        @(negedge clk_i);
        kontrol("ara_rst_bitti_yok", 32'(bitti_sayac - b0), 0);
      end
    end
    if (!iptal) cerceve(3, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
